// File: rtl/mmu_io_master.sv
// IO bus master for the MMU register block: runs a fixed boot programming
// sequence after reset, then serves host IO read/write requests with an
// ADDR / STRB / HOLD bus cycle.
module mmu_io_master #(
    parameter int unsigned STRB_CYC    = 2,
    parameter bit          INIT_EN     = 1'b1,
    parameter logic [23:0] MAP_INIT    = 24'o11111110,
    parameter logic [1:0]  CLKDIV_INIT = 2'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       init_done,
    output logic [7:0] io_a,
    output logic [7:0] io_dout,
    output logic       io_doe,
    input  logic [7:0] io_din,
    output logic       iorq_n,
    output logic       rd_n,
    output logic       wr_n
);

    typedef enum logic [1:0] {IDLE, ADDR, STRB, HOLD} state_t;

    localparam logic [3:0] STRB_LAST = 4'(STRB_CYC - 1);
    localparam logic [3:0] BOOT_LAST = 4'd10;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] strb_cnt;
    logic [3:0] boot_step;
    logic       cur_we;
    logic       cur_boot;
    logic [7:0] cur_addr;
    logic [7:0] cur_data;
    logic       start_boot;
    logic       start_host;
    logic       strb_end;

    // Port address of each boot step: unlock read, eight bank maps, clock divider, lock.
    function automatic logic [7:0] boot_addr(input logic [3:0] step);
        logic [7:0] a;
        case (step)
            4'd0:    a = 8'hD1;
            4'd9:    a = 8'hD0;
            4'd10:   a = 8'hD1;
            default: a = 8'hD7 + {4'b0000, step};
        endcase
        return a;
    endfunction

    // Data of each boot step; bank fields are zero-extended from 3 bits.
    function automatic logic [7:0] boot_data(input logic [3:0] step);
        logic [7:0]  d;
        logic [23:0] fields;
        fields = 24'h0;
        case (step)
            4'd0:    d = 8'h00;
            4'd9:    d = {6'b000000, CLKDIV_INIT};
            4'd10:   d = 8'h00;
            default: begin
                fields = MAP_INIT >> (3 * (int'(step) - 1));
                d      = {5'b00000, fields[2:0]};
            end
        endcase
        return d;
    endfunction

    assign start_boot = (state == IDLE) && INIT_EN && !init_done;
    assign start_host = (state == IDLE) && init_done && req;
    assign strb_end   = (state == STRB) && (strb_cnt == STRB_LAST);

    // Bus FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_boot || start_host) state_nxt = ADDR;
            ADDR:    state_nxt = STRB;
            STRB:    if (strb_end) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the transaction (boot step or host request) when a bus cycle starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_addr <= 8'h00;
            cur_data <= 8'h00;
            cur_we   <= 1'b0;
            cur_boot <= 1'b0;
        end else if (start_boot) begin
            cur_addr <= boot_addr(boot_step);
            cur_data <= boot_data(boot_step);
            cur_we   <= (boot_step != 4'd0);
            cur_boot <= 1'b1;
        end else if (start_host) begin
            cur_addr <= addr;
            cur_data <= wdata;
            cur_we   <= we;
            cur_boot <= 1'b0;
        end
    end

    // Count strobe cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strb_cnt <= 4'd0;
        end else if (state == ADDR) begin
            strb_cnt <= 4'd0;
        end else if ((state == STRB) && !strb_end) begin
            strb_cnt <= strb_cnt + 4'd1;
        end
    end

    // Advance the boot sequencer at the end of each boot bus cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            boot_step <= 4'd0;
            init_done <= 1'b0;
        end else if (!INIT_EN) begin
            init_done <= 1'b1;
        end else if ((state == HOLD) && cur_boot) begin
            if (boot_step == BOOT_LAST) begin
                init_done <= 1'b1;
            end else begin
                boot_step <= boot_step + 4'd1;
            end
        end
    end

    // Host completion pulse and read data capture; boot reads never reach rdata.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack   <= 1'b0;
            rdata <= 8'h00;
        end else begin
            ack <= (state == HOLD) && !cur_boot;
            if (strb_end && !cur_we && !cur_boot) begin
                rdata <= io_din;
            end
        end
    end

    // Strobes decode straight from state so reset releases them immediately.
    always_comb begin
        iorq_n  = (state != STRB);
        rd_n    = !((state == STRB) && !cur_we);
        wr_n    = !((state == STRB) && cur_we);
        io_a    = cur_addr;
        io_dout = cur_data;
        io_doe  = cur_we && (state != IDLE);
        busy    = (state != IDLE) || (!init_done && (boot_step != 4'd0));
    end

endmodule

// File: tb/tb_mmu_io_master.sv
// Self-checking bench for mmu_io_master: default instance for boot, host and
// reset behaviour; a STRB_CYC=1, INIT_EN=0 instance for back-to-back requests.
module tb_mmu_io_master;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic [3:0] len;
    } rec_t;

    localparam logic [23:0] MAP = 24'o11111110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, req, we;
    logic [7:0] addr, wdata, io_din;
    logic       ack, busy, init_done, io_doe, iorq_n, rd_n, wr_n;
    logic [7:0] rdata, io_a, io_dout;

    logic       reset2, req2, we2;
    logic [7:0] addr2, wdata2, io_din2;
    logic       ack2, busy2, init_done2, io_doe2, iorq_n2, rd_n2, wr_n2;
    logic [7:0] rdata2, io_a2, io_dout2;

    mmu_io_master dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .busy(busy), .init_done(init_done),
        .io_a(io_a), .io_dout(io_dout), .io_doe(io_doe), .io_din(io_din),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n)
    );

    mmu_io_master #(.STRB_CYC(1), .INIT_EN(1'b0)) dut2 (
        .clk(clk), .reset(reset2), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .ack(ack2), .rdata(rdata2), .busy(busy2), .init_done(init_done2),
        .io_a(io_a2), .io_dout(io_dout2), .io_doe(io_doe2), .io_din(io_din2),
        .iorq_n(iorq_n2), .rd_n(rd_n2), .wr_n(wr_n2)
    );

    int n_cmp = 0;
    int n_err = 0;

    rec_t mq0[$];
    rec_t mq1[$];
    rec_t eq0[$];
    rec_t eq1[$];
    bit   ec0[$];
    bit   ec1[$];
    int   viol[2];
    int   low_cnt[2];
    int   ack_cnt[2];
    rec_t cur[2];
    int   doe_bad = 0;
    logic [7:0] dev_val = 8'h00;
    logic [7:0] dev_val2 = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] key(input rec_t r, input bit c);
        return c ? r : {r.we, r.addr, 8'h00, r.len};
    endfunction

    // Bus observer: turns each strobe window into one record and counts rule breaks.
    task automatic mon_step(input int id, input logic rq, r, w, doe, ak,
                            input logic [7:0] a, d);
        rec_t rc;
        if (ak) ack_cnt[id]++;
        if (!r && !w) viol[id]++;
        if ((!r || !w) && rq) viol[id]++;
        if (!rq) begin
            if (r && w) viol[id]++;
            if (!w && !doe) viol[id]++;
            if (!r && doe) viol[id]++;
            if (low_cnt[id] == 0) begin
                cur[id].we   = !w;
                cur[id].addr = a;
                cur[id].data = !w ? d : 8'h00;
            end else if (a !== cur[id].addr || (!w && d !== cur[id].data)) begin
                viol[id]++;
            end
            low_cnt[id]++;
        end else if (low_cnt[id] != 0) begin
            rc     = cur[id];
            rc.len = 4'(low_cnt[id]);
            if (id == 0) mq0.push_back(rc);
            else         mq1.push_back(rc);
            low_cnt[id] = 0;
        end
    endtask

    always @(negedge clk) mon_step(0, iorq_n, rd_n, wr_n, io_doe, ack, io_a, io_dout);
    always @(negedge clk) mon_step(1, iorq_n2, rd_n2, wr_n2, io_doe2, ack2, io_a2, io_dout2);

    // Bus device: returns dev_val only while the read strobe is low.
    always @(negedge clk) begin
        io_din  = !rd_n  ? dev_val  : ~dev_val;
        io_din2 = !rd_n2 ? dev_val2 : ~dev_val2;
    end

    task automatic exp_push(input int id, input logic w, input logic [7:0] a,
                            input logic [7:0] d, input int len, input bit c);
        rec_t r;
        r.we = w; r.addr = a; r.data = w ? d : 8'h00; r.len = 4'(len);
        if (id == 0) begin eq0.push_back(r); ec0.push_back(c); end
        else         begin eq1.push_back(r); ec1.push_back(c); end
    endtask

    task automatic exp_boot();
        exp_push(0, 1'b0, 8'hD1, 8'h00, 2, 1'b1);
        for (int k = 0; k < 8; k++)
            exp_push(0, 1'b1, 8'(8'hD8 + k), {5'b00000, MAP[3*k +: 3]}, 2, 1'b1);
        exp_push(0, 1'b1, 8'hD0, 8'h03, 2, 1'b1);
        exp_push(0, 1'b1, 8'hD1, 8'h00, 2, 1'b0);
    endtask

    task automatic check_bus(input int id, input string tag);
        rec_t m[$];
        rec_t e[$];
        bit   c[$];
        if (id == 0) begin m = mq0; e = eq0; c = ec0; end
        else         begin m = mq1; e = eq1; c = ec1; end
        chk({tag, "_count"}, m.size(), e.size());
        for (int i = 0; i < m.size() && i < e.size(); i++)
            chk($sformatf("%s_%0d", tag, i), key(m[i], c[i]), key(e[i], c[i]));
        if (id == 0) begin mq0.delete(); eq0.delete(); ec0.delete(); end
        else         begin mq1.delete(); eq1.delete(); ec1.delete(); end
    endtask

    // One host transaction on the default instance, starting at a falling edge.
    task automatic host(input logic w, input logic [7:0] a, d, dv,
                        output int lat, output logic [7:0] rd_ack);
        dev_val = dv;
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = 0; rd_ack = 8'hxx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                we = 1'($urandom_range(0, 1)); addr = 8'($urandom); wdata = 8'($urandom);
            end
            if (!w && io_doe) doe_bad++;
            if (ack) begin lat = i; rd_ack = rdata; break; end
        end
        req = 1'b0;
        exp_push(0, w, a, d, 2, 1'b1);
    endtask

    initial begin
        int         lat, id_n, ack_n, busy_bad, acks_before, n2;
        logic [7:0] rd_ack, prev, ha, hd, a0, a1, a2, d0, d2;
        logic       w;
        int         ack_at[3];

        reset = 1'b1; reset2 = 1'b1;
        req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00;
        req2 = 1'b0; we2 = 1'b0; addr2 = 8'h00; wdata2 = 8'h00;
        io_din = 8'h00; io_din2 = 8'h00;
        viol[0] = 0; viol[1] = 0; low_cnt[0] = 0; low_cnt[1] = 0;
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        #1 reset = 1'b0; reset2 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_strobes", {iorq_n, rd_n, wr_n}, 3'b111);
        chk("rst_doe", io_doe, 1'b0);
        chk("rst_bus", {io_a, io_dout}, 16'h0000);
        chk("rst_ack_rdata", {ack, rdata}, 9'h000);
        chk("rst_busy_done", {busy, init_done}, 2'b00);
        chk("rst2_busy_done", {busy2, init_done2}, 2'b00);

        // Boot with a host request pending from the middle of it
        dev_val = 8'hA5;
        ha = 8'($urandom); hd = 8'($urandom);
        reset = 1'b1;
        id_n = 0; ack_n = 0; busy_bad = 0;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (n == 10) begin req = 1'b1; we = 1'b1; addr = ha; wdata = hd; end
            if (n <= 54 && busy !== 1'b1) busy_bad++;
            if (n == 55 && busy !== 1'b0) busy_bad++;
            if (init_done === 1'b1 && id_n == 0) id_n = n;
            if (ack === 1'b1 && ack_n == 0) begin ack_n = n; req = 1'b0; end
        end
        req = 1'b0;
        chk("boot_busy", busy_bad, 0);
        chk("init_done_rise", id_n, 55);
        chk("pending_req_ack", ack_n, 60);
        chk("boot_rdata_untouched", rdata, 8'h00);
        exp_boot();
        exp_push(0, 1'b1, ha, hd, 2, 1'b1);
        check_bus(0, "boot_bus");

        // Directed host write and read
        host(1'b1, 8'hDA, 8'h05, 8'h00, lat, rd_ack);
        chk("wr_latency", lat, 5);
        @(negedge clk);
        host(1'b0, 8'hD8, 8'h00, 8'h07, lat, rd_ack);
        chk("rd_latency", lat, 5);
        chk("rd_data", rd_ack, 8'h07);
        chk("rd_doe", doe_bad, 0);
        check_bus(0, "dir_bus");

        // Random host traffic with random gaps
        for (int t = 0; t < 20; t++) begin
            w = 1'($urandom_range(0, 1));
            prev = rdata;
            host(w, 8'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), lat, rd_ack);
            chk($sformatf("rnd_lat_%0d", t), lat, 5);
            if (w) chk($sformatf("rnd_hold_%0d", t), rd_ack, prev);
            else   chk($sformatf("rnd_rd_%0d", t), rd_ack, dev_val);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
        check_bus(0, "rnd_bus");
        chk("rnd_doe", doe_bad, 0);

        // Reset during the strobe of boot write $DB
        reset = 1'b0;
        repeat (2) @(negedge clk);
        mq0.delete();
        reset = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!iorq_n && io_a == 8'hDB) break;
        end
        chk("db_strobe_seen", {iorq_n, wr_n, io_a}, {2'b00, 8'hDB});
        reset = 1'b0;
        #1;
        chk("abort_strobes", {iorq_n, rd_n, wr_n}, 3'b111);
        chk("abort_doe_busy", {io_doe, busy, init_done}, 3'b000);
        acks_before = ack_cnt[0];
        repeat (2) @(negedge clk);
        mq0.delete();
        reset = 1'b1;
        repeat (60) @(negedge clk);
        chk("reboot_done", init_done, 1'b1);
        chk("reboot_no_ack", ack_cnt[0], acks_before);
        exp_boot();
        check_bus(0, "reboot_bus");
        chk("bus_rules0", viol[0], 0);

        // Second instance: no boot, single-cycle strobe, req held for three acks
        @(negedge clk);
        reset2 = 1'b1;
        @(negedge clk);
        chk("noboot_done", {init_done2, busy2}, 2'b10);
        a0 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom);
        d0 = 8'($urandom); d2 = 8'($urandom);
        dev_val2 = 8'($urandom_range(1, 255));
        req2 = 1'b1; we2 = 1'b1; addr2 = a0; wdata2 = d0;
        n2 = 0; ack_at[0] = 0; ack_at[1] = 0; ack_at[2] = 0;
        for (int n = 1; n <= 40 && n2 < 3; n++) begin
            @(negedge clk);
            if (ack2) begin
                ack_at[n2] = n;
                if (n2 == 1) chk("b2b_rdata", rdata2, dev_val2);
                n2++;
                if (n2 == 1) begin we2 = 1'b0; addr2 = a1; end
                if (n2 == 2) begin we2 = 1'b1; addr2 = a2; wdata2 = d2; end
                if (n2 == 3) req2 = 1'b0;
            end
        end
        req2 = 1'b0;
        chk("b2b_ack0", ack_at[0], 4);
        chk("b2b_ack1", ack_at[1], 8);
        chk("b2b_ack2", ack_at[2], 12);
        @(negedge clk);
        exp_push(1, 1'b1, a0, d0, 1, 1'b1);
        exp_push(1, 1'b0, a1, 8'h00, 1, 1'b1);
        exp_push(1, 1'b1, a2, d2, 1, 1'b1);
        check_bus(1, "b2b_bus");
        chk("bus_rules1", viol[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
